// File: rtl/neighbor_expander.sv
// neighbor_expander
//
// Expands one A* node into its eight 8-connected neighbours, one at a time.
// For each neighbour it checks the grid bounds, reads the obstacle map,
// computes the tentative g cost, and pulses the shared evaluation engine.
// It then forwards (x, y, g, f) to the open-list insert over a valid/ready
// stream. After the last neighbour it pulses done together with the
// number of neighbours that were emitted.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    expand request from the open-list pop
//   req_x, req_y, req_g      node being expanded
//   goal_x, goal_y           goal, captured when the request is accepted
//   map_rd_en, map_addr      single-cycle obstacle-map read
//   map_blocked              map data, valid the cycle after map_rd_en
//   eval_enable              one-cycle start pulse to the evaluation engine
//   eval_x/y, eval_g         neighbour coordinates and tentative g
//   eval_goal_x/y            goal that was latched with the request
//   eval_valid, eval_f       engine result
//   out_valid / out_ready    neighbour result stream to the open-list insert
//   out_x/y, out_g, out_f    neighbour result payload
//   done, done_count         end-of-expansion pulse and emitted count
//   busy                     high whenever an expansion is in progress
module neighbor_expander #(
  parameter int GRID_W    = 64,
  parameter int GRID_H    = 64,
  parameter int ADDR_W    = 12,
  parameter int COST_ORTH = 10,
  parameter int COST_DIAG = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [15:0]       req_x,
  input  logic [15:0]       req_y,
  input  logic [31:0]       req_g,
  input  logic [15:0]       goal_x,
  input  logic [15:0]       goal_y,
  output logic              map_rd_en,
  output logic [ADDR_W-1:0] map_addr,
  input  logic              map_blocked,
  output logic              eval_enable,
  output logic [31:0]       eval_g,
  output logic [15:0]       eval_x,
  output logic [15:0]       eval_y,
  output logic [15:0]       eval_goal_x,
  output logic [15:0]       eval_goal_y,
  input  logic              eval_valid,
  input  logic [31:0]       eval_f,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_x,
  output logic [15:0]       out_y,
  output logic [31:0]       out_g,
  output logic [31:0]       out_f,
  output logic              done,
  output logic [3:0]        done_count,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, GEN, MAP, EVAL, WAIT, OUT, NEXT, DONE
  } state_t;

  state_t       state_q;
  logic [2:0]   idx_q;
  logic [3:0]   cnt_q;
  logic [15:0]  cur_x_q;
  logic [15:0]  cur_y_q;
  logic [31:0]  base_g_q;
  logic [15:0]  nb_x_q;
  logic [15:0]  nb_y_q;
  logic         nb_in_q;

  // Neighbour offsets: idx 0..3 are the orthogonal moves, idx 4..7 the diagonals.
  function automatic logic signed [16:0] off_x(input logic [2:0] i);
    case (i)
      3'd0, 3'd4, 3'd5: off_x = 17'sd1;
      3'd1, 3'd6, 3'd7: off_x = -17'sd1;
      default:          off_x = 17'sd0;
    endcase
  endfunction

  function automatic logic signed [16:0] off_y(input logic [2:0] i);
    case (i)
      3'd2, 3'd4, 3'd6: off_y = 17'sd1;
      3'd3, 3'd5, 3'd7: off_y = -17'sd1;
      default:          off_y = 17'sd0;
    endcase
  endfunction

  logic [2:0]        gen_idx_d;
  logic [15:0]       src_x_d;
  logic [15:0]       src_y_d;
  logic signed [16:0] nx_d;
  logic signed [16:0] ny_d;
  logic              in_bounds_d;
  logic [ADDR_W-1:0] addr_d;
  logic [32:0]       g_sum_d;
  logic [31:0]       g_sat_d;

  // The neighbour about to be entered is computed one step ahead, so the
  // map read can be launched on the very edge that enters GEN. From IDLE it
  // is neighbour 0 of the incoming request; from NEXT it is idx+1 of the
  // latched node. A 17-bit signed sum lets 0-1 show up as negative, so
  // there is no wrap-around into the opposite edge of the grid.
  always_comb begin
    gen_idx_d   = (state_q == IDLE) ? 3'd0 : idx_q + 3'd1;
    src_x_d     = (state_q == IDLE) ? req_x : cur_x_q;
    src_y_d     = (state_q == IDLE) ? req_y : cur_y_q;
    nx_d        = $signed({1'b0, src_x_d}) + off_x(gen_idx_d);
    ny_d        = $signed({1'b0, src_y_d}) + off_y(gen_idx_d);
    in_bounds_d = !nx_d[16] && !ny_d[16]
                  && ({16'd0, nx_d[15:0]} < 32'(GRID_W))
                  && ({16'd0, ny_d[15:0]} < 32'(GRID_H));
    addr_d      = ADDR_W'(ny_d[15:0]) * ADDR_W'(GRID_W) + ADDR_W'(nx_d[15:0]);
    g_sum_d     = {1'b0, base_g_q} + (idx_q[2] ? 33'(COST_DIAG) : 33'(COST_ORTH));
    g_sat_d     = g_sum_d[32] ? 32'hFFFF_FFFF : g_sum_d[31:0];
  end

  // Single sequencer. Pulse outputs (map_rd_en, eval_enable, done) default
  // low every cycle and are raised only on the transition into the state
  // that owns them, so each one is registered and lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      cnt_q       <= 4'd0;
      cur_x_q     <= 16'd0;
      cur_y_q     <= 16'd0;
      base_g_q    <= 32'd0;
      nb_x_q      <= 16'd0;
      nb_y_q      <= 16'd0;
      nb_in_q     <= 1'b0;
      req_ready   <= 1'b1;
      map_rd_en   <= 1'b0;
      map_addr    <= '0;
      eval_enable <= 1'b0;
      eval_g      <= 32'd0;
      eval_x      <= 16'd0;
      eval_y      <= 16'd0;
      eval_goal_x <= 16'd0;
      eval_goal_y <= 16'd0;
      out_valid   <= 1'b0;
      out_x       <= 16'd0;
      out_y       <= 16'd0;
      out_g       <= 32'd0;
      out_f       <= 32'd0;
      done        <= 1'b0;
      done_count  <= 4'd0;
      busy        <= 1'b0;
    end else begin
      map_rd_en   <= 1'b0;
      eval_enable <= 1'b0;
      done        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cur_x_q     <= req_x;
            cur_y_q     <= req_y;
            base_g_q    <= req_g;
            eval_goal_x <= goal_x;
            eval_goal_y <= goal_y;
            idx_q       <= 3'd0;
            cnt_q       <= 4'd0;
            req_ready   <= 1'b0;
            busy        <= 1'b1;
            nb_x_q      <= nx_d[15:0];
            nb_y_q      <= ny_d[15:0];
            nb_in_q     <= in_bounds_d;
            map_rd_en   <= in_bounds_d;
            if (in_bounds_d) map_addr <= addr_d;
            state_q     <= GEN;
          end
        end
        GEN: begin
          state_q <= nb_in_q ? MAP : NEXT;
        end
        MAP: begin
          if (map_blocked) begin
            state_q <= NEXT;
          end else begin
            eval_enable <= 1'b1;
            eval_x      <= nb_x_q;
            eval_y      <= nb_y_q;
            eval_g      <= g_sat_d;
            state_q     <= EVAL;
          end
        end
        EVAL: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (eval_valid) begin
            out_f     <= eval_f;
            out_x     <= nb_x_q;
            out_y     <= nb_y_q;
            out_g     <= eval_g;
            out_valid <= 1'b1;
            state_q   <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            cnt_q     <= cnt_q + 4'd1;
            state_q   <= NEXT;
          end
        end
        NEXT: begin
          if (idx_q == 3'd7) begin
            done       <= 1'b1;
            done_count <= cnt_q;
            state_q    <= DONE;
          end else begin
            idx_q     <= idx_q + 3'd1;
            nb_x_q    <= nx_d[15:0];
            nb_y_q    <= ny_d[15:0];
            nb_in_q   <= in_bounds_d;
            map_rd_en <= in_bounds_d;
            if (in_bounds_d) map_addr <= addr_d;
            state_q   <= GEN;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_expander.sv
// tb_neighbor_expander
//
// Directed and randomized expansions of neighbor_expander. A small obstacle
// map and a one-cycle evaluation engine (f = g + Manhattan distance to goal)
// answer the DUT. A reference model derives the expected neighbour list,
// read and evaluate counts, and cycle totals straight from the move rules.
module tb_neighbor_expander;

  localparam int GW = 64;
  localparam int GH = 64;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [15:0]   req_x, req_y;
  logic [31:0]   req_g;
  logic [15:0]   goal_x, goal_y;
  logic          map_rd_en;
  logic [AW-1:0] map_addr;
  logic          map_blocked;
  logic          eval_enable;
  logic [31:0]   eval_g;
  logic [15:0]   eval_x, eval_y, eval_goal_x, eval_goal_y;
  logic          eval_valid;
  logic [31:0]   eval_f;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_x, out_y;
  logic [31:0]   out_g, out_f;
  logic          done;
  logic [3:0]    done_count;
  logic          busy;

  bit mapMem [0:GW*GH-1];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          x;
    int          y;
    logic [31:0] g;
    logic [31:0] f;
  } nb_t;

  nb_t expQ[$];
  int  expRd;
  int  expCycles;

  always #5 clk = ~clk;

  neighbor_expander #(
    .GRID_W(GW), .GRID_H(GH), .ADDR_W(AW), .COST_ORTH(10), .COST_DIAG(14)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_g(req_g),
    .goal_x(goal_x), .goal_y(goal_y),
    .map_rd_en(map_rd_en), .map_addr(map_addr), .map_blocked(map_blocked),
    .eval_enable(eval_enable), .eval_g(eval_g),
    .eval_x(eval_x), .eval_y(eval_y),
    .eval_goal_x(eval_goal_x), .eval_goal_y(eval_goal_y),
    .eval_valid(eval_valid), .eval_f(eval_f),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_g(out_g), .out_f(out_f),
    .done(done), .done_count(done_count), .busy(busy)
  );

  function automatic logic [31:0] absDiff(input int a, input int b);
    return (a > b) ? 32'(a - b) : 32'(b - a);
  endfunction

  // Obstacle map memory: data appears the cycle after the read strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) map_blocked <= 1'b0;
    else     map_blocked <= map_rd_en ? mapMem[map_addr] : 1'b0;
  end

  // Evaluation engine with one cycle of latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eval_valid <= 1'b0;
      eval_f     <= 32'd0;
    end else begin
      eval_valid <= eval_enable;
      eval_f     <= eval_g + absDiff(int'(eval_x), int'(eval_goal_x))
                           + absDiff(int'(eval_y), int'(eval_goal_y));
    end
  end

  // Expected behaviour of one expansion, straight from the move table.
  function automatic void buildModel(input int x, input int y, input logic [31:0] g,
                                     input int gx, input int gy);
    int     dx [8] = '{1, -1, 0, 0, 1, 1, -1, -1};
    int     dy [8] = '{0, 0, 1, -1, 1, -1, 1, -1};
    longint sum;
    nb_t    n;
    expQ.delete();
    expRd     = 0;
    expCycles = 1;
    for (int k = 0; k < 8; k++) begin
      int nx = x + dx[k];
      int ny = y + dy[k];
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
        expCycles += 2;
      end else begin
        expRd++;
        if (mapMem[ny*GW + nx]) begin
          expCycles += 3;
        end else begin
          sum = longint'(g) + ((k < 4) ? 10 : 14);
          n.x = nx;
          n.y = ny;
          n.g = (sum > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
          n.f = n.g + absDiff(nx, gx) + absDiff(ny, gy);
          expQ.push_back(n);
          expCycles += 6;
        end
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one expansion. mode 0: out_ready high, 1: random out_ready,
  // 2: out_ready low for 5 cycles at the first output. rstAt != 0 asserts
  // reset on that cycle after accept and abandons the request.
  task automatic applyStimulus(input int x, input int y, input logic [31:0] g,
                               input int gx, input int gy, input int mode, input int rstAt);
    int          cyc = 0, waitCnt = 0, rdCnt = 0, evCnt = 0, outIdx = 0, held = 0;
    logic        gotDone = 1'b0, outstanding = 1'b0, abandoned = 1'b0;
    logic [15:0] snapX = '0, snapY = '0;
    logic [31:0] snapF = '0;
    buildModel(x, y, g, gx, gy);
    @(negedge clk);
    while (!req_ready && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_x     = 16'(x);
    req_y     = 16'(y);
    req_g     = g;
    goal_x    = 16'(gx);
    goal_y    = 16'(gy);
    req_valid = 1'b1;
    out_ready = (mode == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_x     = 16'hFFFF;
    req_y     = 16'hFFFF;
    goal_x    = 16'h5555;
    goal_y    = 16'h5555;
    while (!gotDone && !abandoned && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (rstAt != 0 && cyc == rstAt) begin
        checkOutput("pre_rst_in_wait", 32'(eval_valid), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_eval_enable", 32'(eval_enable), 32'd0);
        checkOutput("rst_eval_g", eval_g, 32'd0);
        checkOutput("rst_eval_x", 32'(eval_x), 32'd0);
        checkOutput("rst_out_f", out_f, 32'd0);
        checkOutput("rst_out_x", 32'(out_x), 32'd0);
        checkOutput("rst_map_addr", 32'(map_addr), 32'd0);
        checkOutput("rst_done_count", 32'(done_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("rst_no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checkOutput("post_rst_no_done", 32'(done), 32'd0);
          checkOutput("post_rst_no_output", 32'(out_valid), 32'd0);
        end
        abandoned = 1'b1;
      end else begin
        if (mode == 1) begin
          out_ready = 1'($urandom_range(0, 1));
        end else if (mode == 2) begin
          if (held > 0 && held < 5) begin
            checkOutput("bp_valid_held", 32'(out_valid), 32'd1);
            checkOutput("bp_x_stable", 32'(out_x), 32'(snapX));
            checkOutput("bp_y_stable", 32'(out_y), 32'(snapY));
            checkOutput("bp_f_stable", out_f, snapF);
            checkOutput("bp_no_eval", 32'(eval_enable), 32'd0);
            held++;
            out_ready = 1'b0;
          end else if (held == 0 && out_valid) begin
            snapX = out_x;
            snapY = out_y;
            snapF = out_f;
            held = 1;
            out_ready = 1'b0;
          end else begin
            out_ready = 1'b1;
          end
        end else begin
          out_ready = 1'b1;
        end
        if (map_rd_en) rdCnt++;
        if (eval_enable) begin
          checkOutput("eval_overlap", 32'(outstanding), 32'd0);
          outstanding = 1'b1;
          if (evCnt < expQ.size()) begin
            checkOutput("eval_x", 32'(eval_x), 32'(expQ[evCnt].x));
            checkOutput("eval_y", 32'(eval_y), 32'(expQ[evCnt].y));
            checkOutput("eval_g", eval_g, expQ[evCnt].g);
            checkOutput("eval_goal_x", 32'(eval_goal_x), 32'(gx));
            checkOutput("eval_goal_y", 32'(eval_goal_y), 32'(gy));
          end
          evCnt++;
        end
        if (eval_valid) outstanding = 1'b0;
        if (out_valid && out_ready) begin
          if (outIdx < expQ.size()) begin
            checkOutput("out_x", 32'(out_x), 32'(expQ[outIdx].x));
            checkOutput("out_y", 32'(out_y), 32'(expQ[outIdx].y));
            checkOutput("out_g", out_g, expQ[outIdx].g);
            checkOutput("out_f", out_f, expQ[outIdx].f);
          end else begin
            checkOutput("extra_output", 32'(outIdx), 32'(expQ.size()));
          end
          outIdx++;
        end
        if (done) begin
          gotDone = 1'b1;
          checkOutput("done_count", 32'(done_count), 32'(expQ.size()));
        end
      end
    end
    if (!abandoned) begin
      checkOutput("done_seen", 32'(gotDone), 32'd1);
      checkOutput("out_count", 32'(outIdx), 32'(expQ.size()));
      checkOutput("map_reads", 32'(rdCnt), 32'(expRd));
      checkOutput("eval_pulses", 32'(evCnt), 32'(expQ.size()));
      if (mode == 0) checkOutput("cycles_to_done", 32'(cyc), 32'(expCycles));
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("req_ready_after", 32'(req_ready), 32'd1);
      checkOutput("busy_after", 32'(busy), 32'd0);
    end
  endtask

  function automatic void clearMap();
    for (int i = 0; i < GW*GH; i++) mapMem[i] = 1'b0;
  endfunction

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_x     = '0;
    req_y     = '0;
    req_g     = '0;
    goal_x    = '0;
    goal_y    = '0;
    out_ready = 1'b0;
    clearMap();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_map_rd_en", 32'(map_rd_en), 32'd0);
    checkOutput("reset_eval_enable", 32'(eval_enable), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    rst = 1'b0;

    $display("[TB] centre node, empty map");
    applyStimulus(10, 10, 32'd0, 10, 10, 0, 0);

    $display("[TB] corner nodes");
    applyStimulus(0, 0, 32'd100, 5, 7, 0, 0);
    applyStimulus(63, 63, 32'd7, 0, 0, 0, 0);

    $display("[TB] blocked cells around (5,5)");
    mapMem[5*GW + 6] = 1'b1;
    mapMem[4*GW + 4] = 1'b1;
    applyStimulus(5, 5, 32'd20, 30, 2, 0, 0);
    clearMap();

    $display("[TB] backpressure on first output");
    applyStimulus(10, 10, 32'd50, 12, 3, 2, 0);

    $display("[TB] g saturation");
    applyStimulus(10, 10, 32'hFFFF_FFF8, 1, 1, 0, 0);

    $display("[TB] reset during WAIT of idx 3");
    applyStimulus(10, 10, 32'd0, 10, 10, 0, 22);
    applyStimulus(1, 1, 32'd3, 9, 9, 0, 0);

    $display("[TB] randomized expansions");
    for (int t = 0; t < 16; t++) begin
      int          x, y, gx, gy, mode;
      logic [31:0] g;
      for (int i = 0; i < GW*GH; i++) mapMem[i] = ($urandom_range(0, 3) == 0);
      x    = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : GW-1)
                                         : int'($urandom_range(0, GW-1));
      y    = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : GH-1)
                                         : int'($urandom_range(0, GH-1));
      gx   = int'($urandom_range(0, GW-1));
      gy   = int'($urandom_range(0, GH-1));
      g    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 20)))
                                         : 32'($urandom_range(0, 100000));
      mode = int'($urandom_range(0, 1));
      applyStimulus(x, y, g, gx, gy, mode, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
